iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the fixed 64-bit shift-by-one block.
- Shifts a WIDTH-bit operand by a run-time amount, up to STEP bit positions per clock.
- Supports four modes: logical left, logical right, arithmetic right and rotate left.
- Sits between the register-file read stage and ALU writeback. Uses valid/ready handshakes on both sides so the ALU can stall it.

Parameters:
- WIDTH, 64, operand width in bits; power of 2, at least 8.
- STEP, 4, maximum bit positions shifted per cycle; power of 2, 1 <= STEP <= WIDTH.
- AW, $clog2(WIDTH), width of the shift amount (derived; not overridden).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request; 1 only in IDLE.
- in_data  in  WIDTH  operand.
- in_amt  in  AW  shift amount, 0..WIDTH-1.
- in_mode  in  2  shift mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.

Behaviour:
- Reset (reset_n low, effective immediately):
  - state = IDLE.
  - out_valid = 0, out_data = 0, in_ready = 1.
  - Internal remaining count = 0, mode register = 0.
- Accept:
  - Occurs on an edge with in_valid && in_ready.
  - Captures in_data into the working register, in_amt into rem, and in_mode.
  - No capture happens outside IDLE. Requests presented outside IDLE are ignored and must be held by the source.
- IDLE:
  - On accept with in_amt == 0: go to DONE; out_data = in_data.
  - On accept with in_amt != 0: go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - k = min(rem, STEP).
  - Working register shifted by k per the captured mode; rem -= k.
  - If rem becomes 0: go to DONE and load the result into out_data.
- Per-mode fill rules:
  - SLL: zero-fill at the LSB.
  - SRL: zero-fill at the MSB.
  - SRA: replicate bit WIDTH-1 of the original operand.
  - ROL: bits leaving the MSB re-enter at the LSB.
- DONE:
  - out_valid = 1; out_data is held stable.
  - On out_valid && out_ready: go to IDLE, out_valid = 0 on the next cycle.
  - in_ready stays 0 throughout DONE; there is no same-cycle hand-off of a new request.
- Latency: out_valid rises 1 + ceil(in_amt/STEP) cycles after the accept edge.
  - in_amt = 0 gives 1 cycle.
  - The worst case is 1 + (WIDTH-1+STEP-1)/STEP cycles.
- Backpressure: while out_ready = 0 in DONE, out_data and out_valid are held indefinitely and nothing else is accepted.
- Inputs in_data, in_amt and in_mode are don't-care outside the accept edge.
- Reset mid-SHIFT or mid-DONE aborts the operation: the in-flight result is discarded and no out_valid pulse appears.
- No X propagation: all registers are reset, including the working register.

Optional Feature:
- Macro: ITER_SHIFTER_STICKY_EN.
- When defined:
  - Adds port out_sticky (out, 1).
  - out_sticky is the OR of every bit shifted out of the operand during the operation, for SLL/SRL/SRA.
  - out_sticky is 0 for ROL and for in_amt = 0.
  - It is accumulated per SHIFT cycle, cleared on accept, reset to 0, and valid with out_valid.
- When not defined: the port and its accumulator are absent; all other behaviour is identical.

Test Plan (WIDTH=64, STEP=4):
- SLL, data 0x8000_0000_0000_0001, amt 1 -> out_data 0x0000_0000_0000_0002; out_valid 2 cycles after accept; sticky 1.
- SRA, data 0x8000_0000_0000_0000, amt 8 -> out_data 0xFF80_0000_0000_0000; latency 3; sticky 0.
- ROL, data 0x0000_0000_0000_0001, amt 63 -> out_data 0x8000_0000_0000_0000; latency 17.
- SRL, data 0xDEAD, amt 0 -> out_data 0xDEAD; latency 1.
  - in_valid held high through DONE: second request accepted only on the edge after the out handshake.
- Hold out_ready = 0 for 5 cycles in DONE -> out_valid/out_data stable and in_ready = 0; raise out_ready -> IDLE, in_ready = 1 next cycle.
- Assert reset_n low during SHIFT (SLL, amt 40) -> out_valid = 0 and in_ready = 1 immediately; release -> no spurious result; next request (SRL, 0xF0, amt 4) -> 0x0F.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle barrel-less shifter: SLL/SRL/SRA/ROL by up to STEP bits per clock.
// Optional ITER_SHIFTER_STICKY_EN adds out_sticky (OR of all bits shifted out).
module iter_shifter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ITER_SHIFTER_STICKY_EN
  output logic             out_sticky,
`endif
  output logic [WIDTH-1:0] out_data
);

  // One extra bit so STEP == WIDTH and WIDTH itself are representable.
  localparam int unsigned KW = AW + 1;
  localparam logic [KW-1:0] STEP_K  = KW'(STEP);
  localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {M_SLL = 2'b00, M_SRL = 2'b01, M_SRA = 2'b10, M_ROL = 2'b11} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [AW-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [KW-1:0]     k;
  logic [WIDTH-1:0]  shifted;

  always_comb begin
    k = ({1'b0, rem_q} > STEP_K) ? STEP_K : {1'b0, rem_q};
    unique case (mode_q)
      M_SLL:   shifted = work_q << k;
      M_SRL:   shifted = work_q >> k;
      // MSB never changes under >>>, so it always equals the original operand's sign.
      M_SRA:   shifted = WIDTH'($signed(work_q) >>> k);
      default: shifted = (work_q << k) | (work_q >> (WIDTH_K - k));
    endcase
  end

`ifdef ITER_SHIFTER_STICKY_EN
  localparam logic [WIDTH-1:0] ONES = '1;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] lost_bits;

  always_comb begin
    unique case (mode_q)
      M_SLL:          lost_bits = work_q & ~(ONES >> k);
      M_SRL, M_SRA:   lost_bits = work_q & ~(ONES << k);
      default:        lost_bits = '0;
    endcase
  end

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == S_IDLE && in_valid)
      sticky_d = 1'b0;
    else if (state_q == S_SHIFT)
      sticky_d = sticky_q | (|lost_bits);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end

  assign out_sticky = sticky_q;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    work_d     = work_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d = in_data;
          rem_d  = in_amt;
          mode_d = mode_t'(in_mode);
          if (in_amt == '0) begin
            state_d    = S_DONE;
            out_data_d = in_data;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - k[AW-1:0];
        if ({1'b0, rem_q} == k) begin
          state_d    = S_DONE;
          out_data_d = shifted;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_SLL;
      work_q     <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter (WIDTH=64, STEP=4).
module tb_iter_shifter;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned STEP  = 4;
  localparam int unsigned AW    = 6;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [AW-1:0]    in_amt = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  int n_checks = 0;
  int n_errors = 0;

  iter_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ITER_SHIFTER_STICKY_EN
    .out_sticky(out_sticky),
`endif
    .out_data  (out_data)
  );

`ifndef ITER_SHIFTER_STICKY_EN
  assign out_sticky = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sticky(input string tag, input logic exp);
`ifdef ITER_SHIFTER_STICKY_EN
    chk(tag, 64'(out_sticky), 64'(exp));
`endif
  endtask

  // Entered and left at posedge+1. hold = cycles of out_ready low while in DONE.
  task automatic do_op(input string tag, input logic [1:0] mode, input logic [63:0] data,
                       input logic [5:0] amt, input logic [63:0] exp, input int exp_lat,
                       input logic exp_st, input int hold);
    int lat;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_mode = mode; in_data = data; in_amt = amt; out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0; in_data = 64'hA5A5_A5A5_A5A5_A5A5; in_amt = 6'h2A; in_mode = ~mode;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".data"}, out_data, exp);
    chk({tag, ".busy"}, 64'(in_ready), 64'd0);
    chk_sticky({tag, ".sticky"}, exp_st);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_data"}, out_data, exp);
      chk({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".post_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic seen;
    #12;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data", out_data, 64'd0);
    chk_sticky("rst.sticky", 1'b0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    do_op("sll1",  2'b00, 64'h8000_0000_0000_0001, 6'd1,  64'h0000_0000_0000_0002, 2,  1'b1, 0);
    do_op("sra8",  2'b10, 64'h8000_0000_0000_0000, 6'd8,  64'hFF80_0000_0000_0000, 3,  1'b0, 5);
    do_op("rol63", 2'b11, 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000, 17, 1'b0, 0);
    do_op("sll5",  2'b00, 64'h0000_0000_0000_00FF, 6'd5,  64'h0000_0000_0000_1FE0, 3,  1'b0, 0);
    do_op("srl3",  2'b01, 64'h8000_0000_0000_00FF, 6'd3,  64'h1000_0000_0000_001F, 2,  1'b1, 0);
    do_op("sra63", 2'b10, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b0, 0);
    do_op("rol4",  2'b11, 64'h8000_0000_0000_0001, 6'd4,  64'h0000_0000_0000_0018, 2,  1'b0, 0);

    // in_valid held high through DONE; the second request waits for the handshake.
    in_valid = 1'b1; in_mode = 2'b01; in_data = 64'hDEAD; in_amt = 6'd0; out_ready = 1'b0;
    @(posedge clock); #1;
    chk("srl0.valid", 64'(out_valid), 64'd1);
    chk("srl0.data", out_data, 64'hDEAD);
    chk("srl0.busy", 64'(in_ready), 64'd0);
    chk_sticky("srl0.sticky", 1'b0);
    in_mode = 2'b00; in_data = 64'h1234; in_amt = 6'd0;
    repeat (2) begin @(posedge clock); #1; end
    chk("srl0.no_capture", out_data, 64'hDEAD);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("srl0.idle_valid", 64'(out_valid), 64'd0);
    chk("srl0.idle_rdy", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("second.valid", 64'(out_valid), 64'd1);
    chk("second.data", out_data, 64'h1234);
    chk("second.busy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("second.done", 64'(in_ready), 64'd1);

    // Reset in the middle of a long shift discards the operation.
    in_valid = 1'b1; in_mode = 2'b00; in_data = 64'h0000_0000_0000_0003; in_amt = 6'd40;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    @(negedge clock) reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      seen = seen | out_valid;
    end
    chk("abort.no_result", 64'(seen), 64'd0);
    do_op("srl4", 2'b01, 64'h0000_0000_0000_00F0, 6'd4, 64'h0000_0000_0000_000F, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
